wb_queue: RTL and testbench

WB_QUEUE -- requirements
Module: wb_queue

---
 rtl/wb_queue.sv | 108 ++++++++++
 tb/tb_wb_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Four-entry writeback queue merging two writeback sources into one register-file write port.
// Also flags decode-stage read addresses that still have a write pending.
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        src0_valid,
    input  logic [4:0]  src0_wa,
    input  logic [31:0] src0_wd,
    output logic        src0_ready,
    input  logic        src1_valid,
    input  logic [4:0]  src1_wa,
    input  logic [31:0] src1_wd,
    output logic        src1_ready,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    input  logic [4:0]  qry_ra0,
    input  logic [4:0]  qry_ra1,
    output logic        qry_hit0,
    output logic        qry_hit1,
    output logic [2:0]  count,
    output logic        full,
    output logic        empty
);

    localparam logic [2:0] CAP = 3'(DEPTH);

    logic [4:0]  ent_wa [4];
    logic [31:0] ent_wd [4];
    logic [1:0]  head;
    logic [1:0]  tail;
    logic [1:0]  tail_p1;
    logic [2:0]  cnt;
    logic [2:0]  free;
    logic        enq0;
    logic        enq1;
    logic        pop;
    logic [1:0]  push_n;
    logic [3:0]  live;
    logic [3:0]  match0;
    logic [3:0]  match1;
    logic [1:0]  offset;

    // Space is judged from the registered count only; a pop this cycle frees nothing until next cycle.
    always_comb begin
        free       = CAP - cnt;
        src0_ready = !rst && (free != 3'd0);
        enq0       = src0_valid && src0_ready && (src0_wa != 5'd0);
        src1_ready = !rst && (enq0 ? (free >= 3'd2) : (free >= 3'd1));
        enq1       = src1_valid && src1_ready && (src1_wa != 5'd0);
        pop        = (cnt != 3'd0);
        push_n     = {1'b0, enq0} + {1'b0, enq1};
        tail_p1    = tail + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (enq0) begin
            ent_wa[tail] <= src0_wa;
            ent_wd[tail] <= src0_wd;
        end
        if (enq1) begin
            ent_wa[enq0 ? tail_p1 : tail] <= src1_wa;
            ent_wd[enq0 ? tail_p1 : tail] <= src1_wd;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= 2'd0;
            tail <= 2'd0;
            cnt  <= 3'd0;
        end else begin
            if (pop) begin
                head <= head + 2'd1;
            end
            tail <= tail + push_n;
            cnt  <= cnt + {1'b0, push_n} - {2'b00, pop};
        end
    end

    // An entry is live when its distance from head is below the occupancy.
    always_comb begin
        live   = 4'd0;
        match0 = 4'd0;
        match1 = 4'd0;
        offset = 2'd0;
        for (int i = 0; i < 4; i++) begin
            offset    = 2'(i) - head;
            live[i]   = ({1'b0, offset} < cnt);
            match0[i] = (ent_wa[i] == qry_ra0);
            match1[i] = (ent_wa[i] == qry_ra1);
        end
        qry_hit0 = (qry_ra0 != 5'd0) && |(live & match0);
        qry_hit1 = (qry_ra1 != 5'd0) && |(live & match1);
    end

    always_comb begin
        rf_we = pop;
        rf_wa = pop ? ent_wa[head] : 5'd0;
        rf_wd = pop ? ent_wd[head] : 32'd0;
        count = cnt;
        full  = (cnt == CAP);
        empty = (cnt == 3'd0);
    end

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: the driver pushes accepted writes into an expected queue,
// and a negedge monitor pops and compares them as the DUT presents register-file writes.
module tb_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        src0_valid;
    logic [4:0]  src0_wa;
    logic [31:0] src0_wd;
    logic        src0_ready;
    logic        src1_valid;
    logic [4:0]  src1_wa;
    logic [31:0] src1_wd;
    logic        src1_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  qry_ra0;
    logic [4:0]  qry_ra1;
    logic        qry_hit0;
    logic        qry_hit1;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } entry_t;

    entry_t exp_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 1'b0;

    wb_queue #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .src0_valid (src0_valid),
        .src0_wa    (src0_wa),
        .src0_wd    (src0_wd),
        .src0_ready (src0_ready),
        .src1_valid (src1_valid),
        .src1_wa    (src1_wa),
        .src1_wd    (src1_wd),
        .src1_ready (src1_ready),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .qry_ra0    (qry_ra0),
        .qry_ra1    (qry_ra1),
        .qry_hit0   (qry_hit0),
        .qry_hit1   (qry_hit1),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit modelHit(input logic [4:0] ra);
        if (ra == 5'd0) return 1'b0;
        foreach (exp_q[i]) if (exp_q[i].wa == ra) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle of stimulus, entered 1ns after a rising edge; returns 1ns after the next one.
    task automatic applyStimulus(input logic v0, input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic v1, input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic [4:0] ra0, input logic [4:0] ra1);
        int  space;
        bit  r0, r1, take0;
        src0_valid = v0; src0_wa = wa0; src0_wd = wd0;
        src1_valid = v1; src1_wa = wa1; src1_wd = wd1;
        qry_ra0 = ra0;   qry_ra1 = ra1;
        #1;
        space = 4 - exp_q.size();
        r0    = (space >= 1);
        take0 = v0 && r0 && (wa0 != 5'd0);
        r1    = take0 ? (space >= 2) : (space >= 1);
        checkOutput("src0_ready", src0_ready, r0);
        checkOutput("src1_ready", src1_ready, r1);
        @(posedge clk);
        #1;
        if (take0) exp_q.push_back('{wa: wa0, wd: wd0});
        if (v1 && r1 && (wa1 != 5'd0)) exp_q.push_back('{wa: wa1, wd: wd1});
    endtask

    task automatic idleCycle(input logic [4:0] ra0, input logic [4:0] ra1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra0, ra1);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic resetPulse();
        src0_valid = 1'b1; src0_wa = 5'd6; src0_wd = 32'hDEAD;
        src1_valid = 1'b1; src1_wa = 5'd8; src1_wd = 32'hBEEF;
        qry_ra0 = (exp_q.size() != 0) ? exp_q[0].wa : 5'd6;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_rf_we", rf_we, 1'b0);
        checkOutput("rst_rf_wa", rf_wa, 5'd0);
        checkOutput("rst_rf_wd", rf_wd, 32'd0);
        checkOutput("rst_count", count, 3'd0);
        checkOutput("rst_empty", empty, 1'b1);
        checkOutput("rst_full", full, 1'b0);
        checkOutput("rst_ready0", src0_ready, 1'b0);
        checkOutput("rst_ready1", src1_ready, 1'b0);
        checkOutput("rst_hit0", qry_hit0, 1'b0);
        #1;
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            checkOutput("count", count, exp_q.size());
            checkOutput("empty", empty, exp_q.size() == 0);
            checkOutput("full", full, exp_q.size() == 4);
            checkOutput("qry_hit0", qry_hit0, modelHit(qry_ra0));
            checkOutput("qry_hit1", qry_hit1, modelHit(qry_ra1));
            checkOutput("rf_we", rf_we, exp_q.size() != 0);
            if (rf_we && exp_q.size() != 0) begin
                checkOutput("rf_wa", rf_wa, exp_q[0].wa);
                checkOutput("rf_wd", rf_wd, exp_q[0].wd);
                void'(exp_q.pop_front());
            end else if (!rf_we) begin
                checkOutput("rf_wa_idle", rf_wa, 5'd0);
                checkOutput("rf_wd_idle", rf_wd, 32'd0);
            end
        end
    end

    initial begin
        logic        v0, v1;
        logic [4:0]  wa0, wa1, ra0, ra1;
        int          prob;

        rst = 1'b1;
        src0_valid = 1'b0; src0_wa = 5'd0; src0_wd = 32'd0;
        src1_valid = 1'b1; src1_wa = 5'd3; src1_wd = 32'd1;
        qry_ra0 = 5'd5; qry_ra1 = 5'd3;
        #12;
        checkOutput("init_count", count, 3'd0);
        checkOutput("init_empty", empty, 1'b1);
        checkOutput("init_full", full, 1'b0);
        checkOutput("init_rf_we", rf_we, 1'b0);
        checkOutput("init_ready1", src1_ready, 1'b0);
        checkOutput("init_hit1", qry_hit1, 1'b0);
        src1_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        $display("[TB] single write");
        applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        checkOutput("single_rf_we", rf_we, 1'b1);
        checkOutput("single_rf_wa", rf_wa, 5'd5);
        checkOutput("single_rf_wd", rf_wd, 32'h1234);
        idleCycle(5'd0, 5'd0);
        checkOutput("single_empty", empty, 1'b1);

        $display("[TB] dual push");
        applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 5'd0, 5'd0);
        checkOutput("dual_count", count, 3'd2);
        checkOutput("dual_first", rf_wa, 5'd3);
        idleCycle(5'd0, 5'd0);
        checkOutput("dual_second", rf_wa, 5'd4);
        idleCycle(5'd0, 5'd0);

        $display("[TB] x0 filter");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
        checkOutput("x0_count", count, 3'd0);
        checkOutput("x0_rf_we", rf_we, 1'b0);

        $display("[TB] hazard query");
        applyStimulus(1'b1, 5'd7, 32'h70, 1'b1, 5'd9, 32'h90, 5'd9, 5'd0);
        #1;
        checkOutput("haz_hit0", qry_hit0, 1'b1);
        checkOutput("haz_hit1_zero", qry_hit1, 1'b0);
        idleCycle(5'd9, 5'd0);
        checkOutput("haz_hit0_head", qry_hit0, 1'b1);
        idleCycle(5'd9, 5'd0);
        checkOutput("haz_hit0_gone", qry_hit0, 1'b0);

        $display("[TB] saturation and wrap");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom,
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            checkOutput("sat_count_le4", count <= 3'd4, 1'b1);
        end
        for (int i = 0; i < 5; i++) idleCycle(5'd0, 5'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h110, 5'd0, 5'd0);
        applyStimulus(1'b1, 5'd12, 32'h120, 1'b1, 5'd13, 32'h130, 5'd0, 5'd0);
        checkOutput("pre_rst_count", count, 3'd3);
        resetPulse();
        checkOutput("post_rst_rf_we", rf_we, 1'b0);
        idleCycle(5'd11, 5'd12);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            prob = (i / 50) % 2 == 0 ? 85 : 35;
            v0  = ($urandom_range(0, 99) < prob);
            v1  = ($urandom_range(0, 99) < prob);
            wa0 = 5'($urandom_range(0, 11));
            wa1 = 5'($urandom_range(0, 11));
            ra0 = (exp_q.size() != 0 && $urandom_range(0, 1) == 1) ? exp_q[$urandom_range(0, exp_q.size() - 1)].wa
                                                                   : 5'($urandom_range(0, 11));
            ra1 = 5'($urandom_range(0, 11));
            if ($urandom_range(0, 99) == 0) resetPulse();
            else applyStimulus(v0, wa0, $urandom, v1, wa1, $urandom, ra0, ra1);
        end
        for (int i = 0; i < 6; i++) idleCycle(5'd0, 5'd0);
        checkOutput("drain_empty", empty, 1'b1);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
